// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared constants for the execute-stage ALU:
//     - ALU_* : registered ALU control codes reported on alu_ctrl
//     - FC_*  : R-type functionCode values (only meaningful with ALUop 00)
//     - ALUOP_*: ALUop encodings from the main decoder
//     - state_e: sequencing states of the iterative mul/div path
//   alu_decode() folds ALUop/functionCode into one ALU control code.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_ADDR = 4'b0110;

  localparam logic [3:0] FC_ADD = 4'b0001;
  localparam logic [3:0] FC_SUB = 4'b0010;
  localparam logic [3:0] FC_MUL = 4'b0100;
  localparam logic [3:0] FC_DIV = 4'b1000;

  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_MEM   = 2'b01;
  localparam logic [1:0] ALUOP_AND   = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Unknown R-type function codes fall back to a plain add (address add code).
  function automatic logic [3:0] alu_decode(input logic [1:0] alu_op,
                                            input logic [3:0] fc);
    logic [3:0] code;
    code = ALU_ADDR;
    case (alu_op)
      ALUOP_RTYPE: begin
        case (fc)
          FC_ADD:  code = ALU_ADD;
          FC_SUB:  code = ALU_SUB;
          FC_MUL:  code = ALU_MUL;
          FC_DIV:  code = ALU_DIV;
          default: code = ALU_ADDR;
        endcase
      end
      ALUOP_MEM: code = ALU_ADDR;
      ALUOP_AND: code = ALU_AND;
      default:   code = ALU_OR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_if
//   Bundle between the ID/EX stage (master) and the execute unit (slave).
//   master drives: in_valid, functionCode, ALUop, op_a, op_b, flush
//   slave drives : in_ready, out_valid, result, result_hi, alu_ctrl,
//                  div_by_zero, stall
// ---------------------------------------------------------------------------
interface alu_exec_unit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       functionCode;
  logic [1:0]       ALUop;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [3:0]       alu_ctrl;
  logic             div_by_zero;
  logic             stall;

  modport master (
    output in_valid, functionCode, ALUop, op_a, op_b, flush,
    input  in_ready, out_valid, result, result_hi, alu_ctrl, div_by_zero, stall
  );

  modport slave (
    input  in_valid, functionCode, ALUop, op_a, op_b, flush,
    output in_ready, out_valid, result, result_hi, alu_ctrl, div_by_zero, stall
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// ---------------------------------------------------------------------------
// alu_muldiv_iter
//   Unsigned iterative core, one bit per cycle, WIDTH iterations per op.
//   Ports:
//     clk, reset      : clock, synchronous active-high reset
//     start           : load magnitudes and begin (is_div selects divide)
//     abort           : drop the running operation (counter cleared)
//     a_mag, b_mag    : unsigned operand magnitudes
//     done            : high during the cycle of the final iteration
//     hi, lo          : mul -> {hi,lo} product; div -> lo quotient, hi remainder
// ---------------------------------------------------------------------------
module alu_muldiv_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Multiply: right-shifting shift-add with the multiplier in lo.
  assign add_sum = {1'b0, hi_q} + {1'b0, b_q};
  // Divide: restoring step; the dividend shifts out of lo into hi.
  assign shifted = {hi_q, lo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, b_q};

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      hi_d  = '0;
      lo_d  = a_mag;
      b_d   = b_mag;
      div_d = is_div;
      cnt_d = CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (div_q) begin
        // trial[WIDTH] is the borrow: set means the divisor did not fit.
        if (!trial[WIDTH]) begin
          hi_d = trial[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (lo_q[0]) begin
          hi_d = add_sum[WIDTH:1];
          lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[WIDTH-1:1]};
          lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Execute-stage ALU: ALUop/functionCode decode plus add/sub/and/or in one
//   cycle, and (with ALU_MULDIV_EN defined) iterative signed mul/div that
//   holds the pipeline through in_ready/stall.
//   Build option: ALU_MULDIV_EN -- when undefined, mul/div return 0 in one
//   cycle, in_ready is constant 1 and the RUN/FIX sequencing is absent.
//   Ports:
//     clk   : clock
//     reset : synchronous active-high reset
//     bus   : alu_exec_unit_if.slave (operands, handshake, results)
// ---------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic            clk,
  input logic            reset,
  alu_exec_unit_if.slave bus
);

  logic [3:0]       ctrl_dec;
  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic             dbz_q, dbz_d;
  logic             out_valid_q, out_valid_d;

  assign ctrl_dec = alu_decode(bus.ALUop, bus.functionCode);
  // flush beats a simultaneous in_valid.
  assign accept   = bus.in_valid & in_ready & ~bus.flush;

  always_comb begin
    simple_res = '0;
    case (ctrl_dec)
      ALU_ADD, ALU_ADDR: simple_res = bus.op_a + bus.op_b;
      ALU_SUB:           simple_res = bus.op_a - bus.op_b;
      ALU_AND:           simple_res = bus.op_a & bus.op_b;
      ALU_OR:            simple_res = bus.op_a | bus.op_b;
      default:           simple_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  state_e             state_q, state_d;
  logic               sign_q, sign_d;     // product / quotient sign
  logic               rsign_q, rsign_d;   // remainder follows the dividend
  logic               is_div_q, is_div_d;
  logic               a_sign, b_sign;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               core_start, core_abort, core_done;
  logic [WIDTH-1:0]   core_hi, core_lo;
  logic [2*WIDTH-1:0] prod_mag, prod_signed;
  logic [WIDTH-1:0]   quot_signed, rem_signed;

  assign a_sign = bus.op_a[WIDTH-1];
  assign b_sign = bus.op_b[WIDTH-1];
  // The most-negative value maps to 2^(WIDTH-1), still exact as unsigned.
  assign a_mag  = a_sign ? -bus.op_a : bus.op_a;
  assign b_mag  = b_sign ? -bus.op_b : bus.op_b;

  assign in_ready   = (state_q == IDLE);
  assign core_abort = bus.flush & (state_q != IDLE);

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (core_start),
    .abort  (core_abort),
    .is_div (ctrl_dec == ALU_DIV),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .done   (core_done),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  assign prod_mag    = {core_hi, core_lo};
  assign prod_signed = sign_q ? -prod_mag : prod_mag;
  assign quot_signed = sign_q ? -core_lo : core_lo;
  assign rem_signed  = rsign_q ? -core_hi : core_hi;
`else
  assign in_ready = 1'b1;
`endif

  always_comb begin
    result_d    = result_q;
    result_hi_d = result_hi_q;
    alu_ctrl_d  = alu_ctrl_q;
    dbz_d       = 1'b0;
    out_valid_d = 1'b0;
`ifdef ALU_MULDIV_EN
    state_d    = state_q;
    sign_d     = sign_q;
    rsign_d    = rsign_q;
    is_div_d   = is_div_q;
    core_start = 1'b0;
    dbz_d      = dbz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ctrl_dec == ALU_MUL || (ctrl_dec == ALU_DIV && bus.op_b != '0)) begin
            core_start = 1'b1;
            sign_d     = a_sign ^ b_sign;
            rsign_d    = a_sign;
            is_div_d   = (ctrl_dec == ALU_DIV);
            state_d    = RUN;
          end else if (ctrl_dec == ALU_DIV) begin
            // Divide by zero never enters RUN.
            result_d    = '1;
            result_hi_d = bus.op_a;
            alu_ctrl_d  = ALU_DIV;
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            result_d    = simple_res;
            result_hi_d = '0;
            alu_ctrl_d  = ctrl_dec;
            dbz_d       = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (core_done) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.flush) begin
          if (is_div_q) begin
            result_d    = quot_signed;
            result_hi_d = rem_signed;
            alu_ctrl_d  = ALU_DIV;
          end else begin
            result_d    = prod_signed[WIDTH-1:0];
            result_hi_d = prod_signed[2*WIDTH-1:WIDTH];
            alu_ctrl_d  = ALU_MUL;
          end
          dbz_d       = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`else
    dbz_d = dbz_q;
    if (accept) begin
      // Mul/div codes fall through simple_res as 0 here.
      result_d    = simple_res;
      result_hi_d = '0;
      alu_ctrl_d  = ctrl_dec;
      dbz_d       = 1'b0;
      out_valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      result_hi_q <= '0;
      alu_ctrl_q  <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_MULDIV_EN
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      rsign_q     <= 1'b0;
      is_div_q    <= 1'b0;
`endif
    end else begin
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      alu_ctrl_q  <= alu_ctrl_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_MULDIV_EN
      state_q     <= state_d;
      sign_q      <= sign_d;
      rsign_q     <= rsign_d;
      is_div_q    <= is_div_d;
`endif
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.stall       = bus.in_valid & ~in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.result_hi   = result_hi_q;
  assign bus.alu_ctrl    = alu_ctrl_q;
  assign bus.div_by_zero = dbz_q;

endmodule
